// File: rtl/sync_event_recorder.sv
// Armed cycle counter that timestamps the first rising edge on each of four sequence lines.
// Optional `ifdef ORDER_CHECK_EN adds a sticky flag for out-of-order captures.
module sync_event_recorder #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             fg_signal,
  input  logic             detonation_signal,
  input  logic             wire_signal,
  input  logic             detector_signal,
  input  logic             rd_req,
  input  logic [1:0]       rd_idx,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [3:0]       ev_seen,
  output logic             order_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_ts [4];
  logic [3:0]       r_ev_seen;
  logic             r_busy;
  logic             r_done;
  logic             r_timeout;
  logic [3:0]       r_sync1, r_sync2, r_edge, r_rise;

  logic [3:0]       w_ev_in;
  logic [3:0]       w_cap;
  logic [3:0]       w_seen_next;

  assign w_ev_in     = {detector_signal, wire_signal, detonation_signal, fg_signal};
  assign w_cap       = (r_state == S_RUN) ? (r_rise & ~r_ev_seen) : 4'b0000;
  assign w_seen_next = r_ev_seen | w_cap;

  // Rise pulse is registered so a capture lands three edges after the first high sample;
  // edges recognised outside RUN are dropped so a line rising just before arm is not counted.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_edge  <= '0;
      r_rise  <= '0;
    end else begin
      r_sync1 <= w_ev_in;
      r_sync2 <= r_sync1;
      r_edge  <= r_sync2;
      r_rise  <= (r_state == S_RUN) ? (r_sync2 & ~r_edge) : 4'b0000;
    end
  end

`ifdef ORDER_CHECK_EN
  logic r_order_err;
  logic w_order_viol;

  // A channel capturing while any lower channel is still missing, same cycle included.
  assign w_order_viol = (w_cap[1] & ~r_ev_seen[0]) |
                        (w_cap[2] & ~(&r_ev_seen[1:0])) |
                        (w_cap[3] & ~(&r_ev_seen[2:0]));

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      r_order_err <= 1'b0;
    end else if (r_state != S_RUN) begin
      if (arm) r_order_err <= 1'b0;
    end else if (w_order_viol) begin
      r_order_err <= 1'b1;
    end
  end

  assign order_err = r_order_err;
`else
  assign order_err = 1'b0;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ev_seen <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      for (int i = 0; i < 4; i++) r_ts[i] <= '1;
    end else begin
      case (r_state)
        S_RUN: begin
          for (int i = 0; i < 4; i++) begin
            if (w_cap[i]) r_ts[i] <= r_cnt;
          end
          r_ev_seen <= w_seen_next;
          // A capture completing the set on the last window cycle wins over the timeout.
          if (&w_seen_next) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (r_cnt == LP_LAST) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + LP_ONE;
          end
        end
        default: begin
          if (arm) begin
            r_state   <= S_RUN;
            r_cnt     <= '0;
            r_ev_seen <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            for (int i = 0; i < 4; i++) r_ts[i] <= '1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= r_ts[rd_idx];
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign timeout = r_timeout;
  assign ev_seen = r_ev_seen;

endmodule

// File: tb/tb_sync_event_recorder.sv
// Bench for sync_event_recorder: two instances (long and short window) driven by shared stimulus,
// checked every cycle against a sample-history model plus directed literal expectations.
module tb_sync_event_recorder;

  localparam int TO_A = 1500;
  localparam int TO_B = 64;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;
`ifdef ORDER_CHECK_EN
  localparam logic ORD_EXP = 1'b1;
`else
  localparam logic ORD_EXP = 1'b0;
`endif

  typedef logic [31:0] ts4_t [4];

  logic        clk = 1'b0;
  logic        rst_n, arm, ev_fg, ev_det, ev_wire, ev_detc, rd_req;
  logic [1:0]  rd_idx;
  logic [31:0] o_rd_data [2];
  logic        o_rd_valid [2];
  logic        o_busy [2];
  logic        o_done [2];
  logic        o_timeout [2];
  logic [3:0]  o_ev_seen [2];
  logic        o_order_err [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  sync_event_recorder #(.CNT_W(32), .TIMEOUT(TO_A)) u_dut_a (
    .CLOCK_50(clk), .rst_n(rst_n), .arm(arm),
    .fg_signal(ev_fg), .detonation_signal(ev_det), .wire_signal(ev_wire), .detector_signal(ev_detc),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_data(o_rd_data[0]), .rd_valid(o_rd_valid[0]),
    .busy(o_busy[0]), .done(o_done[0]), .timeout(o_timeout[0]), .ev_seen(o_ev_seen[0]),
    .order_err(o_order_err[0])
  );

  sync_event_recorder #(.CNT_W(32), .TIMEOUT(TO_B)) u_dut_b (
    .CLOCK_50(clk), .rst_n(rst_n), .arm(arm),
    .fg_signal(ev_fg), .detonation_signal(ev_det), .wire_signal(ev_wire), .detector_signal(ev_detc),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_data(o_rd_data[1]), .rd_valid(o_rd_valid[1]),
    .busy(o_busy[1]), .done(o_done[1]), .timeout(o_timeout[1]), .ev_seen(o_ev_seen[1]),
    .order_err(o_order_err[1])
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: h[k] is the line sample taken k+1 edges ago. A line first seen high at edge k
  // (after a low sample) is stored at edge k+3 with the count of the preceding cycle,
  // provided the recorder was running when the rise was recognised and when it is stored.
  int          m_state [2];  // 0 idle, 1 run, 2 done
  logic [31:0] m_cnt [2];
  logic [31:0] m_ts [2][4];
  logic [3:0]  m_seen [2];
  logic        m_busy [2], m_done [2], m_to [2], m_err [2], m_rdv [2], m_run_prev [2];
  logic [31:0] m_rdd [2];
  logic [3:0]  h [4];

  always @(posedge clk) begin
    logic [3:0] rise;
    logic [3:0] cap;
    logic       was_run;
    int         tov;
    for (int n = 0; n < 2; n++) begin
      tov = (n == 0) ? TO_A : TO_B;
      if (!rst_n) begin
        m_state[n] = 0; m_cnt[n] = 0; m_seen[n] = 0;
        m_busy[n] = 0; m_done[n] = 0; m_to[n] = 0; m_err[n] = 0;
        m_rdv[n] = 0; m_rdd[n] = 0; m_run_prev[n] = 0;
        for (int i = 0; i < 4; i++) m_ts[n][i] = ONES;
      end else begin
        rise = h[2] & ~h[3] & {4{m_run_prev[n]}};
        m_rdv[n] = rd_req;
        if (rd_req) m_rdd[n] = m_ts[n][rd_idx];
        was_run = (m_state[n] == 1);
        if (m_state[n] == 1) begin
          cap = rise & ~m_seen[n];
          for (int i = 0; i < 4; i++) begin
            if (cap[i]) begin
              m_ts[n][i] = m_cnt[n];
`ifdef ORDER_CHECK_EN
              for (int j = 0; j < i; j++) if (!m_seen[n][j]) m_err[n] = 1;
`endif
            end
          end
          m_seen[n] = m_seen[n] | cap;
          if (m_seen[n] == 4'hF) begin
            m_state[n] = 2; m_done[n] = 1; m_busy[n] = 0;
          end else if (m_cnt[n] == 32'(tov - 1)) begin
            m_state[n] = 2; m_done[n] = 1; m_busy[n] = 0; m_to[n] = 1;
          end else begin
            m_cnt[n] = m_cnt[n] + 1;
          end
        end else if (arm) begin
          m_state[n] = 1; m_cnt[n] = 0; m_seen[n] = 0;
          m_busy[n] = 1; m_done[n] = 0; m_to[n] = 0; m_err[n] = 0;
          for (int i = 0; i < 4; i++) m_ts[n][i] = ONES;
        end
        m_run_prev[n] = was_run;
      end
    end
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) h[k] = 4'b0000;
    end else begin
      h[3] = h[2]; h[2] = h[1]; h[1] = h[0];
      h[0] = {ev_detc, ev_wire, ev_det, ev_fg};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int n = 0; n < 2; n++) begin
        check($sformatf("busy[%0d]", n), 32'(o_busy[n]), 32'(m_busy[n]));
        check($sformatf("done[%0d]", n), 32'(o_done[n]), 32'(m_done[n]));
        check($sformatf("timeout[%0d]", n), 32'(o_timeout[n]), 32'(m_to[n]));
        check($sformatf("ev_seen[%0d]", n), 32'(o_ev_seen[n]), 32'(m_seen[n]));
        check($sformatf("order_err[%0d]", n), 32'(o_order_err[n]), 32'(m_err[n]));
        check($sformatf("rd_valid[%0d]", n), 32'(o_rd_valid[n]), 32'(m_rdv[n]));
        if (m_rdv[n]) check($sformatf("rd_data[%0d]", n), o_rd_data[n], m_rdd[n]);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Leaves the bench at the negedge inside RUN cycle c.
  task automatic at(input int c);
    while (cyc < c) step();
  endtask

  task automatic arm_run();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    cyc = 0;
  endtask

  task automatic do_reads(input ts4_t ea, input ts4_t eb);
    rd_req = 1'b1;
    rd_idx = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("lit rd_valid a idx%0d", i - 1), 32'(o_rd_valid[0]), 32'd1);
      check($sformatf("lit rd_data a idx%0d", i - 1), o_rd_data[0], ea[i - 1]);
      check($sformatf("lit rd_data b idx%0d", i - 1), o_rd_data[1], eb[i - 1]);
      if (i < 4) rd_idx = 2'(i);
      else rd_req = 1'b0;
    end
    step();
    check("lit rd_valid drop", 32'(o_rd_valid[0]), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; rd_req = 1'b0; rd_idx = 2'd0;
    ev_fg = 1'b0; ev_det = 1'b0; ev_wire = 1'b0; ev_detc = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("lit reset busy", 32'(o_busy[0]), 32'd0);
    check("lit reset done", 32'(o_done[0]), 32'd0);
    check("lit reset ev_seen", 32'(o_ev_seen[0]), 32'd0);
    check("lit reset rd_data", o_rd_data[0], 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal sequence
    arm_run();
    check("lit busy on arm", 32'(o_busy[0]), 32'd1);
    at(99);   ev_fg = 1'b1;
    at(299);  ev_det = 1'b1;
    at(999);  ev_wire = 1'b1;
    at(1004); ev_detc = 1'b1;
    at(1007);
    check("lit done before completion", 32'(o_done[0]), 32'd0);
    at(1008);
    check("lit done after completion", 32'(o_done[0]), 32'd1);
    check("lit busy after completion", 32'(o_busy[0]), 32'd0);
    check("lit ev_seen full", 32'(o_ev_seen[0]), 32'hF);
    check("lit timeout clear", 32'(o_timeout[0]), 32'd0);
    check("lit order_err clear", 32'(o_order_err[0]), 32'd0);
    check("lit short window timeout", 32'(o_timeout[1]), 32'd1);
    ev_fg = 1'b0; ev_det = 1'b0; ev_wire = 1'b0; ev_detc = 1'b0;
    do_reads('{32'd102, 32'd302, 32'd1002, 32'd1007}, '{ONES, ONES, ONES, ONES});

    // Timeout
    arm_run();
    at(9);  ev_fg = 1'b1;
    at(12); ev_fg = 1'b0;
    at(63);
    check("lit b done at last cycle", 32'(o_done[1]), 32'd0);
    check("lit b busy at last cycle", 32'(o_busy[1]), 32'd1);
    at(64);
    check("lit b done after window", 32'(o_done[1]), 32'd1);
    check("lit b timeout after window", 32'(o_timeout[1]), 32'd1);
    check("lit b ev_seen", 32'(o_ev_seen[1]), 32'h1);
    do_reads('{32'd12, ONES, ONES, ONES}, '{32'd12, ONES, ONES, ONES});
    at(1505);
    check("lit a timeout", 32'(o_timeout[0]), 32'd1);

    // Simultaneous and repeated edges, arm ignored while running
    arm_run();
    at(49); ev_wire = 1'b1; ev_detc = 1'b1;
    at(52); ev_wire = 1'b0; ev_detc = 1'b0;
    at(59); arm = 1'b1;
    at(60); arm = 1'b0;
    at(79); ev_wire = 1'b1;
    at(82); ev_wire = 1'b0;
    at(90);
    check("lit simul ev_seen", 32'(o_ev_seen[0]), 32'hC);
    check("lit simul order_err", 32'(o_order_err[0]), 32'(ORD_EXP));
    do_reads('{ONES, ONES, 32'd52, 32'd52}, '{ONES, ONES, 32'd52, 32'd52});
    at(1505);

    // Order check
    arm_run();
    at(19); ev_detc = 1'b1;
    at(39); ev_fg = 1'b1;
    at(45);
    check("lit order_err set", 32'(o_order_err[0]), 32'(ORD_EXP));
    ev_detc = 1'b0; ev_fg = 1'b0;
    at(70);
    check("lit order_err held", 32'(o_order_err[0]), 32'(ORD_EXP));
    do_reads('{32'd42, ONES, ONES, 32'd22}, '{32'd42, ONES, ONES, 32'd22});
    at(1505);

    // Reset mid-run, then re-arm
    arm_run();
    at(9);  ev_det = 1'b1;
    at(12); ev_det = 1'b0;
    at(30); rst_n = 1'b0;
    at(31); rst_n = 1'b1;
    check("lit rst busy", 32'(o_busy[0]), 32'd0);
    check("lit rst ev_seen", 32'(o_ev_seen[0]), 32'd0);
    check("lit rst rd_data", o_rd_data[0], 32'd0);
    check("lit rst done", 32'(o_done[1]), 32'd0);
    arm_run();
    at(4); ev_fg = 1'b1;
    at(7); ev_fg = 1'b0;
    at(10);
    do_reads('{32'd7, ONES, ONES, ONES}, '{32'd7, ONES, ONES, ONES});
    check("lit rearm busy", 32'(o_busy[0]), 32'd1);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
